// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: scancodes, joystick bit indices and coin FSM states shared by the input controller.
package arcade_input_pkg;
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DOWN = 8'h72;
  localparam logic [7:0] SC_LEFT = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_CTRL = 9'h014;
  localparam logic [8:0] SC_F1 = 9'h005;
  localparam logic [8:0] SC_1 = 9'h016;
  localparam logic [8:0] SC_F2 = 9'h006;
  localparam logic [8:0] SC_2 = 9'h01E;
  localparam logic [8:0] SC_F3 = 9'h004;
  localparam logic [8:0] SC_5 = 9'h02E;
  localparam int J_RIGHT = 0;
  localparam int J_LEFT = 1;
  localparam int J_DOWN = 2;
  localparam int J_UP = 3;
  localparam int J_FIRE = 4;
  localparam int J_START1 = 5;
  localparam int J_START2 = 6;
  localparam int J_COIN = 7;
  typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_WAIT_REL} coin_state_t;
endpackage

// File: rtl/coin_pulser.sv
// coin_pulser: stretches each accepted coin press into exactly COIN_PULSE_CYCLES high cycles.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 1_800_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_raw,
  output logic coin
);
  coin_state_t state;
  logic [23:0] count;
  logic raw_d;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= COIN_IDLE;
      count <= '0;
      raw_d <= 1'b0;
      coin <= 1'b0;
    end else begin
      raw_d <= coin_raw;
      case (state)
        COIN_IDLE: if (coin_raw && !raw_d) begin
          state <= COIN_PULSE;
          count <= 24'(COIN_PULSE_CYCLES - 1);
          coin <= 1'b1;
        end
        COIN_PULSE: if (count == '0) begin
          coin <= 1'b0;
          state <= coin_raw ? COIN_WAIT_REL : COIN_IDLE;
        end else count <= count - 24'd1;
        COIN_WAIT_REL: if (!coin_raw) state <= COIN_IDLE;
        default: state <= COIN_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: PS/2 key latches merged with joystick, orientation remap and coin stretching.
// Optional autofire on the fire output when ARCADE_AUTOFIRE_EN is defined.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 1_800_000,
  parameter int AUTOFIRE_HALF = 600_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        orient_horz,
  input  logic        autofire_on,
  output logic        left,
  output logic        right,
  output logic        fire,
  output logic        start1,
  output logic        start2,
  output logic        coin
);
  logic old_tgl, primed, ev, pr;
  logic [8:0] code;
  logic kup, kdown, kleft, kright, kspace, kctrl, kf1, k1, kf2, k2, kf3, k5;
  logic left_nx, right_nx, fire_raw, fire_nx, coin_raw, unused;
  assign pr = ps2_key[9];
  assign code = ps2_key[8:0];
  // the first cycle after reset only captures the toggle, so a stale level is never an event
  assign ev = primed && (ps2_key[10] != old_tgl);
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_tgl <= 1'b0;
      primed <= 1'b0;
      {kup, kdown, kleft, kright, kspace, kctrl, kf1, k1, kf2, k2, kf3, k5} <= '0;
    end else begin
      old_tgl <= ps2_key[10];
      primed <= 1'b1;
      if (ev) begin
        if (code[7:0] == SC_UP) kup <= pr;
        if (code[7:0] == SC_DOWN) kdown <= pr;
        if (code[7:0] == SC_LEFT) kleft <= pr;
        if (code[7:0] == SC_RIGHT) kright <= pr;
        if (code == SC_SPACE) kspace <= pr;
        if (code == SC_CTRL) kctrl <= pr;
        if (code == SC_F1) kf1 <= pr;
        if (code == SC_1) k1 <= pr;
        if (code == SC_F2) kf2 <= pr;
        if (code == SC_2) k2 <= pr;
        if (code == SC_F3) kf3 <= pr;
        if (code == SC_5) k5 <= pr;
      end
    end
  end
  assign left_nx = orient_horz ? (kdown | joy[J_DOWN]) : (kleft | joy[J_LEFT]);
  assign right_nx = orient_horz ? (kup | joy[J_UP]) : (kright | joy[J_RIGHT]);
  assign fire_raw = kspace | kctrl | joy[J_FIRE];
  assign coin_raw = kf3 | k5 | joy[J_COIN];
`ifdef ARCADE_AUTOFIRE_EN
  logic [23:0] af_cnt;
  logic af_ph;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt <= '0;
      af_ph <= 1'b0;
    end else if (!(autofire_on && fire_raw)) begin
      af_cnt <= '0;
      af_ph <= 1'b0;
    end else if (af_cnt == 24'(AUTOFIRE_HALF - 1)) begin
      af_cnt <= '0;
      af_ph <= ~af_ph;
    end else af_cnt <= af_cnt + 24'd1;
  end
  assign fire_nx = fire_raw & ~(autofire_on & af_ph);
  assign unused = &{1'b0, joy[15:8]};
`else
  assign fire_nx = fire_raw;
  assign unused = &{1'b0, joy[15:8], autofire_on, AUTOFIRE_HALF[0]};
`endif
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      {left, right, fire, start1, start2} <= '0;
    end else begin
      left <= left_nx;
      right <= right_nx;
      fire <= fire_nx;
      start1 <= kf1 | k1 | joy[J_START1];
      start2 <= kf2 | k2 | joy[J_START2];
    end
  end
  coin_pulser #(.COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)) u_coin (
    .clk_sys(clk_sys),
    .reset(reset),
    .coin_raw(coin_raw),
    .coin(coin)
  );
endmodule
